// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_CLEAR = 2'b11
    } state_t;

    // Defaults shared with the counter block.
    localparam int TICK_WIDTH_DEF = 8;
    localparam int LAP_DEPTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 4;

endpackage

// File: rtl/lap_mem_arb.sv
// Lap capture and single-port lap-memory arbitration (write always beats read).
// Latency: lap write 1 cycle after capture; read mem_read +1, rd_valid +2 (out-of-range +1), +1 per conflicting write.
// Backpressure: rd_req ignored while rd_busy; laps dropped when full unless STOPWATCH_LAP_WRAP_EN is defined (then oldest slot overwritten).
// Ports: clr/lap_req from the FSM; unit_tick sampled on capture; mem_* drive the lap memory;
//        rd_req/rd_idx/rd_busy/rd_valid/rd_data form the display read port; lap_count/lap_full/lap_drop are status.
module lap_mem_arb
    import stopwatch_pkg::*;
#(
    parameter int TICK_WIDTH = TICK_WIDTH_DEF,
    parameter int LAP_DEPTH  = LAP_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  lap_req,
    input  logic [TICK_WIDTH-1:0] unit_tick,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [TICK_WIDTH-1:0] mem_data_write,
    input  logic [TICK_WIDTH-1:0] mem_data_read,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [TICK_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   lap_count,
    output logic                  lap_full,
    output logic                  lap_drop
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(LAP_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(LAP_DEPTH - 1);

    logic                  pend_vld;
    logic [TICK_WIDTH-1:0] pend_dat;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  rd_pend;
    logic [ADDR_WIDTH-1:0] rd_idx_q;
    logic                  lap_take;
    logic                  lap_drop_d;
    logic                  in_range;

`ifdef STOPWATCH_LAP_WRAP_EN
    assign lap_take   = lap_req;
    assign lap_drop_d = 1'b0;
`else
    // Occupancy includes the lap still sitting in the pending register,
    // so back-to-back laps near the top cannot overfill the memory.
    logic [ADDR_WIDTH+1:0] occupancy;
    assign occupancy  = {1'b0, lap_count} + {{(ADDR_WIDTH+1){1'b0}}, pend_vld};
    assign lap_take   = lap_req && (occupancy < {1'b0, DEPTH_CNT});
    assign lap_drop_d = lap_req && !lap_take;
`endif

    // Range check is done at issue time, so a lap written just ahead of the
    // read is already counted.
    assign in_range = ({1'b0, rd_idx_q} < lap_count);
    assign lap_full = (lap_count == DEPTH_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld       <= 1'b0;
            pend_dat       <= '0;
            wr_ptr         <= '0;
            lap_count      <= '0;
            lap_drop       <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
            rd_pend        <= 1'b0;
            rd_idx_q       <= '0;
            rd_busy        <= 1'b0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
        end else begin
            // The pending lap always drains next cycle because writes win.
            pend_vld <= lap_take;
            if (lap_take) begin
                pend_dat <= unit_tick;
            end
            lap_drop <= lap_drop_d;

            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            if (pend_vld) begin
                mem_write      <= 1'b1;
                mem_address    <= wr_ptr;
                mem_data_write <= pend_dat;
            end else if (rd_pend && in_range) begin
                mem_read    <= 1'b1;
                mem_address <= rd_idx_q;
            end

            if (clr) begin
                wr_ptr    <= '0;
                lap_count <= '0;
            end else if (pend_vld) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + ADDR_WIDTH'(1);
                if (lap_count != DEPTH_CNT) begin
                    lap_count <= lap_count + (ADDR_WIDTH+1)'(1);
                end
            end

            rd_valid <= 1'b0;
            if (!rd_busy) begin
                if (rd_req) begin
                    rd_busy  <= 1'b1;
                    rd_pend  <= 1'b1;
                    rd_idx_q <= rd_idx;
                end
            end else if (rd_pend && !pend_vld) begin
                rd_pend <= 1'b0;
                // Out-of-range reads complete without touching memory.
                if (!in_range) begin
                    rd_valid <= 1'b1;
                    rd_data  <= '0;
                    rd_busy  <= 1'b0;
                end
            end else if (mem_read) begin
                rd_valid <= 1'b1;
                rd_data  <= mem_data_read;
                rd_busy  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM (IDLE/RUN/PAUSE/CLEAR) plus lap recording via lap_mem_arb.
// Latency: button at edge N changes start/pause/clr after edge N; lap write 1 cycle after capture.
// Backpressure: none on buttons; display reads held off by rd_busy. Optional macro: STOPWATCH_LAP_WRAP_EN.
// Ports: *_btn single-cycle pulses; start/pause/clr counter controls; mem_* lap memory port;
//        rd_* display read port; lap_count/lap_full/lap_drop lap status.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_WIDTH = TICK_WIDTH_DEF,
    parameter int LAP_DEPTH  = LAP_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_btn,
    input  logic                  pause_btn,
    input  logic                  clear_btn,
    input  logic                  lap_btn,
    input  logic [TICK_WIDTH-1:0] unit_tick,
    output logic                  start,
    output logic                  pause,
    output logic                  clr,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [TICK_WIDTH-1:0] mem_data_write,
    input  logic [TICK_WIDTH-1:0] mem_data_read,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [TICK_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   lap_count,
    output logic                  lap_full,
    output logic                  lap_drop
);

    state_t state_q;
    state_t state_d;
    logic   lap_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_btn)      state_d = ST_CLEAR;
                else if (start_btn) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (pause_btn)      state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clear_btn)      state_d = ST_CLEAR;
                else if (start_btn) state_d = ST_RUN;
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        start = 1'b0;
        pause = 1'b0;
        clr   = 1'b0;
        case (state_q)
            ST_RUN:   start = 1'b1;
            ST_PAUSE: pause = 1'b1;
            ST_CLEAR: clr   = 1'b1;
            default: begin
                start = 1'b0;
            end
        endcase
    end

    // A pause in the same cycle suppresses the lap.
    assign lap_req = (state_q == ST_RUN) && lap_btn && !pause_btn;

    lap_mem_arb #(
        .TICK_WIDTH (TICK_WIDTH),
        .LAP_DEPTH  (LAP_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lap_mem_arb (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .lap_req        (lap_req),
        .unit_tick      (unit_tick),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read),
        .rd_req         (rd_req),
        .rd_idx         (rd_idx),
        .rd_busy        (rd_busy),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .lap_count      (lap_count),
        .lap_full       (lap_full),
        .lap_drop       (lap_drop)
    );

endmodule
